// File: rtl/data_mem_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl_pkg
//   Shared definitions for the MEM-stage data-memory controller: data width,
//   FSM state encoding and the byte-lane enable helper.
// ----------------------------------------------------------------------------
package data_mem_ctrl_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Byte enables for a 16-bit word SRAM; bit [1] is the high byte.
    function automatic logic [1:0] lane_enables(input logic is_byte, input logic addr0);
        if (!is_byte) begin
            return 2'b11;
        end
        return addr0 ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl_if
//   Pipeline <-> data-memory controller request/response bundle.
//   master : MEM stage (drives the request, sees stall/response)
//   slave  : data_mem_ctrl
//   Signals:
//     req_valid/req_we/req_byte/req_signed/req_addr/req_wdata  request
//     stall          freeze IF..MEM while the access is outstanding
//     rsp_valid      one-cycle completion pulse
//     mem_err        misaligned word access flag, valid with rsp_valid
//     mem_read_data  load result to WB, holds the last load value
// ----------------------------------------------------------------------------
interface data_mem_ctrl_if;

    logic                                 req_valid;
    logic                                 req_we;
    logic                                 req_byte;
    logic                                 req_signed;
    logic [data_mem_ctrl_pkg::DATA_W-1:0] req_addr;
    logic [data_mem_ctrl_pkg::DATA_W-1:0] req_wdata;
    logic                                 stall;
    logic                                 rsp_valid;
    logic                                 mem_err;
    logic [data_mem_ctrl_pkg::DATA_W-1:0] mem_read_data;

    modport master (
        output req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
        input  stall, rsp_valid, mem_err, mem_read_data
    );

    modport slave (
        input  req_valid, req_we, req_byte, req_signed, req_addr, req_wdata,
        output stall, rsp_valid, mem_err, mem_read_data
    );

endinterface

// File: rtl/data_mem_ctrl_load_align.sv
// ----------------------------------------------------------------------------
// load_align
//   Combinational load formatter: picks the addressed byte lane of a 16-bit
//   read word and sign/zero extends it, or passes the word through.
//   Ports:
//     rdata      in  16  raw SRAM/IO read word
//     addr0      in  1   byte address bit 0 (1 = high lane)
//     is_byte    in  1   1 = byte load, 0 = word load
//     is_signed  in  1   byte load: 1 = sign-extend, 0 = zero-extend
//     data       out 16  extended result
// ----------------------------------------------------------------------------
module load_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic              addr0,
    input  logic              is_byte,
    input  logic              is_signed,
    output logic [DATA_W-1:0] data
);

    logic [7:0] lane;

    assign lane = addr0 ? rdata[15:8] : rdata[7:0];
    assign data = is_byte ? {{8{is_signed & lane[7]}}, lane} : rdata;

endmodule

// File: rtl/data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// data_mem_ctrl
//   MEM-stage data-memory controller. Accepts one load/store from the
//   pipeline, runs a WAIT_STATES+1 cycle access on a synchronous 16-bit word
//   SRAM, stalls the pipeline meanwhile and returns an aligned, extended load
//   word. Misaligned word accesses complete without touching the SRAM and
//   raise mem_err.
//   Parameters:
//     ADDR_W       SRAM word-address width (byte address bits [ADDR_W:1])
//     WAIT_STATES  extra SRAM cycles beyond one, 0..7
//   Ports:
//     clk, rst     clock, synchronous active-high reset
//     bus          data_mem_ctrl_if.slave: pipeline request/response
//     sram_en/we/be/addr/wdata  SRAM control, held for the whole access
//     sram_rdata   SRAM read data, valid in the final access cycle
// ----------------------------------------------------------------------------
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    data_mem_ctrl_if.slave    bus,
    output logic              sram_en,
    output logic              sram_we,
    output logic [1:0]        sram_be,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [2:0] LAST_COUNT = 3'(WAIT_STATES);

    state_t              state;
    state_t              state_nxt;
    logic [2:0]          count;

    // Request captured in IDLE; the SRAM controls are driven from these so
    // they stay constant for the whole access.
    logic                lat_we;
    logic                lat_is_byte;
    logic                lat_is_signed;
    logic                lat_addr0;
    logic                lat_err;
    logic [1:0]          lat_be;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    logic [DATA_W-1:0]   read_data_q;
    logic [DATA_W-1:0]   load_word;
    logic                misaligned;
    logic                last_cycle;
    logic                in_access;

    // Byte address bits above the SRAM window are deliberately ignored.
    logic                unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[DATA_W-1:ADDR_W+1];

    assign misaligned = !bus.req_byte && bus.req_addr[0];
    assign in_access  = (state == ST_ACCESS);
    assign last_cycle = in_access && (count == LAST_COUNT);

    load_align u_load_align (
        .rdata     (sram_rdata),
        .addr0     (lat_addr0),
        .is_byte   (lat_is_byte),
        .is_signed (lat_is_signed),
        .data      (load_word)
    );

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            count         <= 3'd0;
            lat_we        <= 1'b0;
            lat_is_byte   <= 1'b0;
            lat_is_signed <= 1'b0;
            lat_addr0     <= 1'b0;
            lat_err       <= 1'b0;
            lat_be        <= 2'b00;
            lat_addr      <= '0;
            lat_wdata     <= '0;
            read_data_q   <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_we        <= bus.req_we;
                        lat_is_byte   <= bus.req_byte;
                        lat_is_signed <= bus.req_signed;
                        lat_addr0     <= bus.req_addr[0];
                        lat_err       <= misaligned;
                        lat_be        <= lane_enables(bus.req_byte, bus.req_addr[0]);
                        lat_addr      <= bus.req_addr[ADDR_W:1];
                        lat_wdata     <= bus.req_byte ? {2{bus.req_wdata[7:0]}}
                                                      : bus.req_wdata;
                        count         <= 3'd0;
                    end
                end
                ST_ACCESS: begin
                    if (last_cycle) begin
                        // rdata is only valid in the final access cycle.
                        if (!lat_we) begin
                            read_data_q <= load_word;
                        end
                    end else begin
                        count <= count + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        bus.stall     = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.mem_err   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    bus.stall = 1'b1;
                    state_nxt = misaligned ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                bus.stall = 1'b1;
                if (last_cycle) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // req_valid still belongs to the completed instruction here.
                bus.rsp_valid = 1'b1;
                bus.mem_err   = lat_err;
                state_nxt     = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // SRAM controls are gated so the bus is quiet outside an access.
    assign sram_en    = in_access;
    assign sram_we    = in_access & lat_we;
    assign sram_be    = in_access ? lat_be    : 2'b00;
    assign sram_addr  = in_access ? lat_addr  : '0;
    assign sram_wdata = in_access ? lat_wdata : '0;

    assign bus.mem_read_data = read_data_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Bench for data_mem_ctrl with WAIT_STATES=1 and a behavioural 2-cycle
//   SRAM. Expected values come from a transaction-level memory model
//   (array of words + last-load register).
// ----------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int ADDR_W = 8;
    localparam int WS     = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_ctrl_if bus ();

    logic              sram_en;
    logic              sram_we;
    logic [1:0]        sram_be;
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_wdata;
    logic [15:0]       sram_rdata;

    data_mem_ctrl #(
        .ADDR_W      (ADDR_W),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_be    (sram_be),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // ---------------- behavioural SRAM: write/read in the (WS+1)th enabled cycle
    logic [15:0] sram_mem [256];
    int          en_run = 0;
    logic        mem_init = 1'b0;

    function automatic logic [15:0] init_val(input int i);
        return 16'((i * 40503) + 12345);
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) sram_mem[i] <= init_val(i);
        end else if (sram_en && sram_we && en_run == WS) begin
            if (sram_be[0]) sram_mem[sram_addr][7:0]  <= sram_wdata[7:0];
            if (sram_be[1]) sram_mem[sram_addr][15:8] <= sram_wdata[15:8];
        end
        en_run <= sram_en ? en_run + 1 : 0;
    end

    assign sram_rdata = (sram_en && en_run == WS) ? sram_mem[sram_addr] : 16'hDEAD;

    // ---------------- reference model
    logic [15:0] ref_mem [256];
    logic [15:0] ref_rd;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with the controller in IDLE; returns
    // just after the rising edge that ends DONE, with req_valid dropped.
    task automatic do_access(input logic we, input logic is_byte, input logic is_signed,
                             input logic [15:0] addr, input logic [15:0] wdata,
                             output logic [15:0] rd_seen, output logic [1:0] be_seen);
        logic [7:0]  widx;
        logic        misal;
        logic [1:0]  exp_be;
        logic [15:0] exp_wd;
        logic [15:0] word;
        logic [7:0]  lane;
        logic        err_seen;
        int          k, stall_n, en_n, rsp_k;
        bit          seen;

        widx   = addr[8:1];
        misal  = !is_byte && addr[0];
        exp_be = !is_byte ? 2'b11 : (addr[0] ? 2'b10 : 2'b01);
        exp_wd = is_byte ? {wdata[7:0], wdata[7:0]} : wdata;

        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_byte   = is_byte;
        bus.req_signed = is_signed;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;

        k = 0; stall_n = 0; en_n = 0; rsp_k = -1; seen = 0;
        err_seen = 1'b0; rd_seen = 16'h0; be_seen = 2'b00;
        while (!seen && k < 12) begin
            @(negedge clk);
            if (bus.stall) stall_n++;
            if (sram_en) begin
                en_n++;
                be_seen = sram_be;
                check("sram_ctl",
                      64'({sram_we, sram_be, sram_addr, we ? sram_wdata : 16'h0}),
                      64'({we, exp_be, widx, we ? exp_wd : 16'h0}));
            end
            if (bus.rsp_valid) begin
                seen     = 1;
                rsp_k    = k;
                err_seen = bus.mem_err;
                rd_seen  = bus.mem_read_data;
            end else begin
                @(posedge clk);
                #1;
                k++;
            end
        end

        // Model update from the access rules.
        if (!misal) begin
            if (we) begin
                if (!is_byte)     ref_mem[widx]       = wdata;
                else if (addr[0]) ref_mem[widx][15:8] = wdata[7:0];
                else              ref_mem[widx][7:0]  = wdata[7:0];
            end else begin
                word   = ref_mem[widx];
                lane   = addr[0] ? word[15:8] : word[7:0];
                ref_rd = !is_byte ? word
                       : {(is_signed && lane[7]) ? 8'hFF : 8'h00, lane};
            end
        end

        check("rsp_latency", 64'(rsp_k),    64'(misal ? 1 : WS + 2));
        check("stall_cycles", 64'(stall_n), 64'(misal ? 1 : WS + 2));
        check("sram_en_cycles", 64'(en_n),  64'(misal ? 0 : WS + 1));
        check("mem_err", 64'(err_seen),     64'(misal));
        check("read_data", 64'(rd_seen),    64'(ref_rd));

        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rd;
        logic [1:0]  be;

        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        ref_rd = 16'h0;

        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr   = 16'h0;
        bus.req_wdata  = 16'h0;
        rst      = 1'b1;
        mem_init = 1'b1;

        // 1. reset for two cycles
        @(posedge clk); #1; mem_init = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_outs",
              64'({bus.stall, bus.rsp_valid, bus.mem_err, bus.mem_read_data,
                   sram_en, sram_we, sram_be, sram_addr, sram_wdata}), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 2. word store then word load
        do_access(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, rd, be);
        check("t2_store_be", 64'(be), 64'(2'b11));
        do_access(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rd, be);
        check("t2_load", 64'(rd), 64'h BEEF);

        // 3. byte store to high lane, word load of the same word
        do_access(1'b1, 1'b1, 1'b0, 16'h0011, 16'h0080, rd, be);
        check("t3_store_be", 64'(be), 64'(2'b10));
        do_access(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rd, be);
        check("t3_load", 64'(rd), 64'h80EF);

        // 4. byte loads, signed and unsigned (back-to-back)
        do_access(1'b0, 1'b1, 1'b1, 16'h0011, 16'h0000, rd, be);
        check("t4_signed", 64'(rd), 64'hFF80);
        do_access(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, rd, be);
        check("t4_unsigned", 64'(rd), 64'h0080);

        // 5. misaligned word load: error, no SRAM activity, data held
        do_access(1'b0, 1'b0, 1'b0, 16'h0013, 16'h0000, rd, be);
        check("t5_held", 64'(rd), 64'h0080);

        // 6. reset during the ACCESS phase of a load
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_byte   = 1'b0;
        bus.req_addr   = 16'h0010;
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_in_access", 64'(sram_en), 64'h1);
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("t6_after_rst",
              64'({bus.stall, bus.rsp_valid, sram_en, bus.mem_read_data}), 64'h0);
        rst    = 1'b0;
        ref_rd = 16'h0;
        @(posedge clk); #1;
        check("t6_no_rsp", 64'({bus.rsp_valid, bus.stall}), 64'h0);

        // Randomized traffic, including address wrap and misaligned words.
        for (int i = 0; i < 80; i++) begin
            logic        r_we, r_byte, r_signed;
            logic [15:0] r_addr, r_wdata;
            int          gap;
            r_we     = 1'($urandom_range(0, 1));
            r_byte   = 1'($urandom_range(0, 1));
            r_signed = 1'($urandom_range(0, 1));
            r_addr   = 16'($urandom) & 16'hFE1F;
            r_wdata  = 16'($urandom);
            do_access(r_we, r_byte, r_signed, r_addr, r_wdata, rd, be);
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(posedge clk); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
